// File: rtl/semaforo_ctrl.sv
// -----------------------------------------------------------------------------
// semaforo_ctrl
//
// Two-way traffic-light controller with pedestrian requests, runtime-
// programmable phase durations and a night flashing mode.
//
// Phase sequence: G1 -> Y1 -> AR1 -> G2 -> Y2 -> AR2 -> G1.
// Night mode enters FLASH from an all-red phase and leaves through AR2.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   ped_req1/2   pedestrian request for crossing 1 / 2 (any-length pulse)
//   night        level request for night flashing
//   cfg_we       configuration write strobe
//   cfg_addr     0 green, 1 yellow, 2 all-red, 3 minimum green
//   cfg_data     duration in cycles (0 behaves as 1)
//   c1, c2       car lights: 0 green, 1 yellow, 2 red, 3 off
//   p1, p2       pedestrian walk lamps
//   phase        current state code
//   pend1/2      latched pending pedestrian request
// -----------------------------------------------------------------------------
module semaforo_ctrl #(
   parameter int unsigned GREEN_DEF  = 6,
   parameter int unsigned YELLOW_DEF = 2,
   parameter int unsigned ALLRED_DEF = 1,
   parameter int unsigned MINGRN_DEF = 2,
   parameter int unsigned BLINK      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_req1,
   input  logic       ped_req2,
   input  logic       night,
   input  logic       cfg_we,
   input  logic [1:0] cfg_addr,
   input  logic [3:0] cfg_data,
   output logic [1:0] c1,
   output logic [1:0] c2,
   output logic       p1,
   output logic       p2,
   output logic [2:0] phase,
   output logic       pend1,
   output logic       pend2
);

   typedef enum logic [2:0] {
      ST_G1    = 3'd0,
      ST_Y1    = 3'd1,
      ST_AR1   = 3'd2,
      ST_G2    = 3'd3,
      ST_Y2    = 3'd4,
      ST_AR2   = 3'd5,
      ST_FLASH = 3'd6
   } state_t;

   localparam logic [1:0] LT_GREEN  = 2'd0;
   localparam logic [1:0] LT_YELLOW = 2'd1;
   localparam logic [1:0] LT_RED    = 2'd2;
   localparam logic [1:0] LT_OFF    = 2'd3;

   localparam int unsigned BLINK_W = (BLINK > 1) ? $clog2(BLINK) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK - 1);

   localparam logic [3:0] GREEN_RST  = 4'(GREEN_DEF);
   localparam logic [3:0] YELLOW_RST = 4'(YELLOW_DEF);
   localparam logic [3:0] ALLRED_RST = 4'(ALLRED_DEF);
   localparam logic [3:0] MINGRN_RST = 4'(MINGRN_DEF);
   // The reset state is AR2, so its shadow starts from the all-red default.
   localparam logic [3:0] SHADOW_RST = (ALLRED_RST == 4'd0) ? 4'd1 : ALLRED_RST;

   // A programmed duration of zero still occupies one cycle.
   function automatic logic [3:0] sat_dur(input logic [3:0] v);
      return (v == 4'd0) ? 4'd1 : v;
   endfunction

   // Elapsed count saturates at 15 so it never wraps inside a state.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   state_t               state_q,     state_d;
   logic [3:0]           elapsed_q,   elapsed_d;
   logic [3:0]           shadow_q,    shadow_d;
   logic [3:0]           green_q,     green_d;
   logic [3:0]           yellow_q,    yellow_d;
   logic [3:0]           allred_q,    allred_d;
   logic [3:0]           mingrn_q,    mingrn_d;
   logic                 pend1_q,     pend1_d;
   logic                 pend2_q,     pend2_d;
   logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
   logic                 blink_off_q, blink_off_d;
   logic [1:0]           c1_q,        c1_d;
   logic [1:0]           c2_q,        c2_d;
   logic                 p1_q,        p1_d;
   logic                 p2_q,        p2_d;

   logic                 done;
   logic                 min_hit;
   logic                 entering;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_AR2;
         elapsed_q   <= 4'd0;
         shadow_q    <= SHADOW_RST;
         green_q     <= GREEN_RST;
         yellow_q    <= YELLOW_RST;
         allred_q    <= ALLRED_RST;
         mingrn_q    <= MINGRN_RST;
         pend1_q     <= 1'b0;
         pend2_q     <= 1'b0;
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
         c1_q        <= LT_RED;
         c2_q        <= LT_RED;
         p1_q        <= 1'b0;
         p2_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         elapsed_q   <= elapsed_d;
         shadow_q    <= shadow_d;
         green_q     <= green_d;
         yellow_q    <= yellow_d;
         allred_q    <= allred_d;
         mingrn_q    <= mingrn_d;
         pend1_q     <= pend1_d;
         pend2_q     <= pend2_d;
         blink_cnt_q <= blink_cnt_d;
         blink_off_q <= blink_off_d;
         c1_q        <= c1_d;
         c2_q        <= c2_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // Shadow is always >= 1, so this subtraction never underflows.
      done    = (elapsed_q == (shadow_q - 4'd1));
      min_hit = (elapsed_q >= (sat_dur(mingrn_q) - 4'd1));

      state_d = state_q;
      unique case (state_q)
         ST_G1:    if (done || (pend2_q && min_hit)) state_d = ST_Y1;
         ST_Y1:    if (done) state_d = ST_AR1;
         ST_AR1:   if (done) state_d = night ? ST_FLASH : ST_G2;
         ST_G2:    if (done || (pend1_q && min_hit)) state_d = ST_Y2;
         ST_Y2:    if (done) state_d = ST_AR2;
         ST_AR2:   if (done) state_d = night ? ST_FLASH : ST_G1;
         ST_FLASH: begin
            // Leave only after a complete off half-period.
            if ((blink_cnt_q == BLINK_LAST) && blink_off_q && !night)
               state_d = ST_AR2;
         end
         default:  state_d = ST_AR2;
      endcase

      // Every transition changes the state code, so a change marks an entry.
      entering = (state_d != state_q);

      elapsed_d = entering ? 4'd0 : sat_inc(elapsed_q);

      // The duration seen at entry is frozen for the whole state.
      shadow_d = shadow_q;
      if (entering) begin
         unique case (state_d)
            ST_G1, ST_G2:   shadow_d = sat_dur(green_q);
            ST_Y1, ST_Y2:   shadow_d = sat_dur(yellow_q);
            ST_AR1, ST_AR2: shadow_d = sat_dur(allred_q);
            default:        shadow_d = 4'd1;
         endcase
      end

      // Flash half-period tracking; always begins with the lit half.
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
      if ((state_d == ST_FLASH) && !entering) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            blink_off_d = blink_off_q;
         end
      end

      green_d  = green_q;
      yellow_d = yellow_q;
      allred_d = allred_q;
      mingrn_d = mingrn_q;
      if (cfg_we) begin
         unique case (cfg_addr)
            2'd0: green_d  = cfg_data;
            2'd1: yellow_d = cfg_data;
            2'd2: allred_d = cfg_data;
            2'd3: mingrn_d = cfg_data;
            default: ;
         endcase
      end

      // A request seen while its green is starting or running is already served.
      if ((state_q == ST_G1) || (state_d == ST_G1))
         pend1_d = 1'b0;
      else
         pend1_d = pend1_q | ped_req1;

      if ((state_q == ST_G2) || (state_d == ST_G2))
         pend2_d = 1'b0;
      else
         pend2_d = pend2_q | ped_req2;
   end

   // ---------------------------------------------------------------------------
   // Output decode (from the next state, registered)
   // ---------------------------------------------------------------------------
   always_comb begin
      c1_d = LT_RED;
      c2_d = LT_RED;
      p1_d = 1'b0;
      p2_d = 1'b0;
      unique case (state_d)
         ST_G1:    begin c1_d = LT_GREEN;  p1_d = 1'b1; end
         ST_Y1:    c1_d = LT_YELLOW;
         ST_G2:    begin c2_d = LT_GREEN;  p2_d = 1'b1; end
         ST_Y2:    c2_d = LT_YELLOW;
         ST_FLASH: begin
            c1_d = blink_off_d ? LT_OFF : LT_YELLOW;
            c2_d = blink_off_d ? LT_OFF : LT_YELLOW;
         end
         default:  ;
      endcase
   end

   assign c1    = c1_q;
   assign c2    = c2_q;
   assign p1    = p1_q;
   assign p2    = p2_q;
   assign phase = state_q;
   assign pend1 = pend1_q;
   assign pend2 = pend2_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_semaforo_ctrl
//
// Directed scenarios for semaforo_ctrl. The stimulus process pushes the
// hand-derived observation expected after each rising edge into a queue; an
// independent monitor pops one entry per edge and compares.
// -----------------------------------------------------------------------------
module tb_semaforo_ctrl;

   localparam logic [2:0] G1 = 3'd0, Y1 = 3'd1, AR1 = 3'd2, G2 = 3'd3,
                          Y2 = 3'd4, AR2 = 3'd5, FL = 3'd6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ped_req1 = 1'b0;
   logic       ped_req2 = 1'b0;
   logic       night = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = 2'd0;
   logic [3:0] cfg_data = 4'd0;
   logic [1:0] c1, c2;
   logic       p1, p2;
   logic [2:0] phase;
   logic       pend1, pend2;

   semaforo_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .ped_req1 (ped_req1),
      .ped_req2 (ped_req2),
      .night    (night),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .c1       (c1),
      .c2       (c2),
      .p1       (p1),
      .p2       (p2),
      .phase    (phase),
      .pend1    (pend1),
      .pend2    (pend2)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] ph;
      logic [1:0] c1;
      logic [1:0] c2;
      logic       p1;
      logic       p2;
      logic       pd1;
      logic       pd2;
   } obs_t;

   typedef struct packed {
      logic [7:0] tag;
      obs_t       o;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   logic [7:0] tag = 8'd0;

   // Lamp table for the fixed phases: {c1, c2, p1, p2}.
   function automatic logic [5:0] lights(input logic [2:0] ph);
      case (ph)
         3'd0:    return {2'd0, 2'd2, 1'b1, 1'b0};
         3'd1:    return {2'd1, 2'd2, 1'b0, 1'b0};
         3'd2:    return {2'd2, 2'd2, 1'b0, 1'b0};
         3'd3:    return {2'd2, 2'd0, 1'b0, 1'b1};
         3'd4:    return {2'd2, 2'd1, 1'b0, 1'b0};
         3'd5:    return {2'd2, 2'd2, 1'b0, 1'b0};
         default: return {2'd3, 2'd3, 1'b0, 1'b0};
      endcase
   endfunction

   // n edges in a fixed phase with the given pending flags.
   task automatic seg(input int n, input logic [2:0] ph,
                      input logic pd1 = 1'b0, input logic pd2 = 1'b0);
      exp_t e;
      logic [5:0] l;
      l = lights(ph);
      for (int i = 0; i < n; i++) begin
         e.tag   = tag;
         e.o.ph  = ph;
         e.o.c1  = l[5:4];
         e.o.c2  = l[3:2];
         e.o.p1  = l[1];
         e.o.p2  = l[0];
         e.o.pd1 = pd1;
         e.o.pd2 = pd2;
         sb.push_back(e);
         @(negedge clk);
      end
   endtask

   // n edges in FLASH with both car lights at value c.
   task automatic fseg(input int n, input logic [1:0] c,
                       input logic pd1, input logic pd2);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.tag   = tag;
         e.o.ph  = FL;
         e.o.c1  = c;
         e.o.c2  = c;
         e.o.p1  = 1'b0;
         e.o.p2  = 1'b0;
         e.o.pd1 = pd1;
         e.o.pd2 = pd2;
         sb.push_back(e);
         @(negedge clk);
      end
   endtask

   task automatic cfg_set(input logic [1:0] a, input logic [3:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
   endtask

   task automatic cfg_clr();
      cfg_we   = 1'b0;
      cfg_addr = 2'd0;
      cfg_data = 4'd0;
   endtask

   // Monitor: one observation per rising edge, sampled 1 time unit later.
   initial begin
      exp_t e;
      obs_t a;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            a = '{ph: phase, c1: c1, c2: c2, p1: p1, p2: p2, pd1: pend1, pd2: pend2};
            n_vec++;
            if (a !== e.o) begin
               n_miss++;
               $display("FAIL t%0d vec%0d: got ph=%0d c1=%0d c2=%0d p=%b%b pend=%b%b want ph=%0d c1=%0d c2=%0d p=%b%b pend=%b%b",
                        e.tag, n_vec, a.ph, a.c1, a.c2, a.p1, a.p2, a.pd1, a.pd2,
                        e.o.ph, e.o.c1, e.o.c2, e.o.p1, e.o.p2, e.o.pd1, e.o.pd2);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);

      // Reset state
      tag = 8'd0;
      rst = 1'b1;
      seg(2, AR2);
      rst = 1'b0;

      // Default cycle: AR2 1, G1 6, Y1 2, AR1 1, G2 6, Y2 2, AR2 1
      tag = 8'd1;
      seg(6, G1); seg(2, Y1); seg(1, AR1); seg(6, G2); seg(2, Y2); seg(1, AR2);
      seg(6, G1); seg(2, Y1); seg(1, AR1);

      // ped_req1 pulse at G2 elapsed 0 cuts G2 to min-green
      tag = 8'd2;
      seg(1, G2);
      ped_req1 = 1'b1;
      seg(1, G2, 1'b1, 1'b0);
      ped_req1 = 1'b0;
      seg(2, Y2, 1'b1, 1'b0);
      seg(1, AR2, 1'b1, 1'b0);

      // Green=3 written mid-G1: current G1 keeps 6, following greens last 3;
      // green=0 behaves as 1; then green restored to 6
      tag = 8'd3;
      seg(2, G1);
      cfg_set(2'd0, 4'd3);
      seg(1, G1);
      cfg_clr();
      seg(3, G1); seg(2, Y1); seg(1, AR1); seg(3, G2); seg(2, Y2); seg(1, AR2);
      seg(3, G1); seg(1, Y1);
      cfg_set(2'd0, 4'd0);
      seg(1, Y1);
      cfg_clr();
      seg(1, AR1); seg(1, G2); seg(1, Y2);
      cfg_set(2'd0, 4'd6);
      seg(1, Y2);
      cfg_clr();
      seg(1, AR2);

      // Night mode: FLASH after AR1, yellow/off halves of 4, exit via AR2;
      // a request during FLASH latches and later shortens G1
      tag = 8'd4;
      seg(2, G1);
      night = 1'b1;
      seg(4, G1); seg(2, Y1); seg(1, AR1);
      fseg(4, 2'd1, 1'b0, 1'b0);
      fseg(4, 2'd3, 1'b0, 1'b0);
      fseg(2, 2'd1, 1'b0, 1'b0);
      ped_req2 = 1'b1;
      fseg(1, 2'd1, 1'b0, 1'b1);
      ped_req2 = 1'b0;
      fseg(1, 2'd1, 1'b0, 1'b1);
      night = 1'b0;
      fseg(4, 2'd3, 1'b0, 1'b1);
      seg(1, AR2, 1'b0, 1'b1);
      seg(2, G1, 1'b0, 1'b1);
      seg(2, Y1, 1'b0, 1'b1);
      seg(1, AR1, 1'b0, 1'b1);

      // Reset in Y2 with pend2=1 and a modified yellow register
      tag = 8'd5;
      seg(3, G2);
      cfg_set(2'd1, 4'd5);
      seg(1, G2);
      cfg_clr();
      seg(2, G2); seg(1, Y2);
      ped_req2 = 1'b1;
      seg(1, Y2, 1'b0, 1'b1);
      ped_req2 = 1'b0;
      rst = 1'b1;
      seg(1, AR2);
      rst = 1'b0;
      seg(6, G1); seg(2, Y1); seg(1, AR1);

      // ped_req2 held through G2 entry; then both requests in Y1
      tag = 8'd6;
      seg(6, G2); seg(2, Y2); seg(1, AR2);
      seg(6, G1); seg(1, Y1);
      ped_req2 = 1'b1;
      seg(1, Y1, 1'b0, 1'b1);
      seg(1, AR1, 1'b0, 1'b1);
      seg(6, G2);
      ped_req2 = 1'b0;
      seg(2, Y2); seg(1, AR2); seg(6, G1); seg(1, Y1);
      ped_req1 = 1'b1;
      ped_req2 = 1'b1;
      seg(1, Y1, 1'b1, 1'b1);
      ped_req1 = 1'b0;
      ped_req2 = 1'b0;
      seg(1, AR1, 1'b1, 1'b1);
      seg(2, G2, 1'b1, 1'b0);
      seg(2, Y2, 1'b1, 1'b0);
      seg(1, AR2, 1'b1, 1'b0);
      seg(3, G1);

      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending entries, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/semaforo_ctrl.md
SEMAFORO_CTRL -- requirements
Module: semaforo_ctrl

Interface
REQ-001 SHALL have parameter GREEN_DEF, default 6, reset value of green-duration register (cycles).
REQ-002 SHALL have parameter YELLOW_DEF, default 2, reset value of yellow-duration register.
REQ-003 SHALL have parameter ALLRED_DEF, default 1, reset value of all-red-duration register.
REQ-004 SHALL have parameter MINGRN_DEF, default 2, reset value of minimum-green register.
REQ-005 SHALL have parameter BLINK, default 4, cycles per half-period of night flashing.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports ped_req1, ped_req2  input  1 each  pedestrian request for crossing 1 or 2, any-length pulse.
REQ-009 SHALL have port night  input  1  level, requests night flashing mode.
REQ-010 SHALL have ports cfg_we 1 bit, cfg_addr 2 bits, cfg_data 4 bits  input  config write (addr 0 green, 1 yellow, 2 all-red, 3 min-green).
REQ-011 SHALL have ports c1, c2  output  2 each  car lights: 0 green, 1 yellow, 2 red, 3 off.
REQ-012 SHALL have ports p1, p2  output  1 each  pedestrian walk lamps.
REQ-013 SHALL have port phase  output  3  current state code.
REQ-014 SHALL have ports pend1, pend2  output  1 each  latched pending pedestrian request.

Function
REQ-015 SHALL implement states G1=0, Y1=1, AR1=2, G2=3, Y2=4, AR2=5, FLASH=6; phase = state code; all outputs registered.
REQ-016 Outputs per state SHALL be: G1 c1=0 c2=2 p1=1; Y1 c1=1 c2=2; AR1/AR2 c1=2 c2=2; G2 c1=2 c2=0 p2=1; Y2 c1=2 c2=1; p lamps 0 wherever not listed.
REQ-017 Nominal sequence SHALL be G1->Y1->AR1->G2->Y2->AR2->G1.
REQ-018 An elapsed counter SHALL clear to 0 on every state entry and increment each cycle in the state.
REQ-019 On state entry, the state's duration register SHALL be latched into a shadow; the state SHALL exit when elapsed == shadow-1 (state lasts exactly shadow cycles).
REQ-020 A config write SHALL update the register on the next edge; a running state SHALL be unaffected (shadow); a stored value of 0 SHALL be treated as 1.
REQ-021 ped_req1 high on any cycle SHALL set pend1; pend1 SHALL clear on the cycle G1 is entered; symmetric for ped_req2/pend2/G2.
REQ-022 ped_req1 asserted in the same cycle G1 is entered, or while in G1, SHALL NOT set pend1 (request already served).
REQ-023 Early termination: in G2 with pend1=1 and elapsed >= min-green-1, G2 SHALL exit to Y2 next edge; symmetric for G1 with pend2.
REQ-024 night SHALL be sampled only at AR1 or AR2 exit; if 1, next state SHALL be FLASH instead of G2/G1.
REQ-025 In FLASH, c1=c2 SHALL alternate 1 (yellow) and 3 (off) every BLINK cycles, starting with 1; p1=p2=0; pedestrian latches keep accumulating.
REQ-026 FLASH SHALL exit to AR2 at the end of a full off half-period when night=0, then resume normally into G1.
REQ-027 Elapsed counter SHALL be 4 bits wide and SHALL NOT wrap within a state (max duration 15).

Reset
REQ-028 On rst=1 at a clock edge: state=AR2, elapsed=0, shadow=ALLRED_DEF, registers = *_DEF, pend1=pend2=0, c1=c2=2, p1=p2=0, phase=5.
REQ-029 rst SHALL override all other inputs, including mid-state and in FLASH; first post-reset transition SHALL follow REQ-019.

Verification
REQ-030 Reset, no requests, defaults -> AR2 1 cycle, G1 6, Y1 2, AR1 1, G2 6, Y2 2, AR2 1; period 18 cycles, exact c/p values per REQ-016.
REQ-031 ped_req1 one-cycle pulse at G2 elapsed 0 -> pend1=1, G2 lasts 2 cycles, Y2 2, AR2 1, G1 entry clears pend1, p1=1.
REQ-032 Write green=3 mid-G1 -> current G1 keeps 6 cycles, next G2 lasts 3; write green=0 -> next green lasts 1.
REQ-033 night=1 during G1 -> sequence continues to AR1, then FLASH: c1=c2 = 1 for 4, 3 for 4, ...; night=0 -> after off half-period, AR2 1 cycle, then G1.
REQ-034 rst pulsed in Y2 with pend2=1 -> next cycle phase=5, c1=c2=2, pend2=0, registers back to defaults.
REQ-035 ped_req2 held high through G2 entry -> pend2 stays 0 during G2; ped_req1 and ped_req2 together in Y1 -> both latch, G2 not shortened below min-green.
